// File: rtl/instr_fetch_if.sv
// Handshake and bus bundle between the fetch stage, its instruction ROM and the
// control decoder/driver that sequences the program.
interface instr_fetch_if #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int IDX_W   = 5
);
  logic               start;
  logic               stall;
  logic               jump_en;
  logic               branch_taken;
  logic               tbl_we;
  logic [IDX_W-1:0]   tbl_idx;
  logic [PC_W-1:0]    tbl_data;
  logic [INSTR_W-1:0] imem_rdata;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_en;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic [PC_W-1:0]    pc;
  logic               done;

  modport master (
    output start, stall, jump_en, branch_taken, tbl_we, tbl_idx, tbl_data, imem_rdata,
    input  imem_addr, imem_en, instr, instr_valid, pc, done
  );

  modport slave (
    input  start, stall, jump_en, branch_taken, tbl_we, tbl_idx, tbl_data, imem_rdata,
    output imem_addr, imem_en, instr, instr_valid, pc, done
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: program counter, 1-cycle synchronous ROM sequencing, jump/branch
// target table and start/done handshake toward the control decoder.
module instr_fetch #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int TBL_N   = 32,
  parameter int END_PC  = 1023
) (
  input logic          clk,
  input logic          rst_n,
  instr_fetch_if.slave bus
);
  localparam int IDX_W = $clog2(TBL_N);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [PC_W-1:0] pc_q, pc_nxt;
  logic [PC_W-1:0] tbl [TBL_N];
  logic            redirect;

  assign redirect = (state == RUN) && !bus.stall && (bus.jump_en || bus.branch_taken);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= '0;
      pc_q     <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      pc_q     <= pc_nxt;
    end
  end

  // NOTE: the target table is a small register file, so it is reset like any other flop;
  // a reset mid-program must leave no stale targets behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TBL_N; i++) tbl[i] <= '0;
    end else if (bus.tbl_we) begin
      tbl[bus.tbl_idx] <= bus.tbl_data;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    pc_nxt       = pc_q;
    bus.imem_en  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          fetch_pc_nxt = '0;
          state_nxt    = FILL;
        end
      end
      FILL: begin
        bus.imem_en  = 1'b1;
        fetch_pc_nxt = fetch_pc + PC_W'(1);
        pc_nxt       = fetch_pc;
        state_nxt    = RUN;
      end
      RUN: begin
        if (!bus.stall) begin
          bus.imem_en = 1'b1;
          // Redirect wins over end-of-program; the word already fetched at pc+1 is dropped.
          if (redirect) begin
            fetch_pc_nxt = tbl[bus.imem_rdata[IDX_W-1:0]];
            state_nxt    = FILL;
          end else if (pc_q == PC_W'(END_PC)) begin
            state_nxt = DONE;
          end else begin
            pc_nxt       = fetch_pc;
            fetch_pc_nxt = fetch_pc + PC_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.imem_addr   = fetch_pc;
  assign bus.instr       = bus.imem_rdata;
  assign bus.instr_valid = (state == RUN);
  assign bus.pc          = pc_q;
  assign bus.done        = (state == DONE);
endmodule

// File: tb/tb_instr_fetch.sv
// Directed vector bench for instr_fetch: bench-side ROM model, one table row per clock,
// plus a hand-written asynchronous reset sequence in mid-program.
module tb_instr_fetch;
  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;

  typedef struct {
    logic            start, stall, jmp, br, we;
    logic [4:0]      idx;
    logic [PC_W-1:0] data;
    logic            exp_valid, exp_done;
    logic [PC_W-1:0] exp_pc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .IDX_W(5)) bus ();

  instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .TBL_N(32), .END_PC(12)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [INSTR_W-1:0] rom [1024];
  always_ff @(posedge clk) if (bus.imem_en) bus.imem_rdata <= rom[bus.imem_addr];

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;
  int   reset_at;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, st, j, b, w, input logic [4:0] ix, input logic [PC_W-1:0] d,
                     input logic ev, ed, input logic [PC_W-1:0] ep);
    vec_t v;
    v = '{start: s, stall: st, jmp: j, br: b, we: w, idx: ix, data: d,
          exp_valid: ev, exp_done: ed, exp_pc: ep};
    vq.push_back(v);
  endtask

  // Plain running rows: one valid instruction per cycle at consecutive addresses.
  task automatic seq(input int lo, input int hi);
    for (int p = lo; p <= hi; p++) add(0, 0, 0, 0, 0, 0, 0, 1, 0, PC_W'(p));
  endtask

  task automatic apply(input int n);
    vec_t v;
    v = vq[n];
    @(negedge clk);
    bus.start        = v.start;
    bus.stall        = v.stall;
    bus.jump_en      = v.jmp;
    bus.branch_taken = v.br;
    bus.tbl_we       = v.we;
    bus.tbl_idx      = v.idx;
    bus.tbl_data     = v.data;
    @(posedge clk);
    #1;
    check($sformatf("v%0d valid", n), 32'(bus.instr_valid), 32'(v.exp_valid));
    check($sformatf("v%0d done", n), 32'(bus.done), 32'(v.exp_done));
    check($sformatf("v%0d pc", n), 32'(bus.pc), 32'(v.exp_pc));
    if (v.exp_valid) check($sformatf("v%0d instr", n), 32'(bus.instr), 32'(rom[v.exp_pc]));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = INSTR_W'(i * 37 + 1);
    rom[1]  = {4'hC, 5'd1};
    rom[5]  = {4'hC, 5'd3};
    rom[7]  = {4'hD, 5'd4};
    rom[10] = {4'hC, 5'd5};
    rom[40] = {4'hC, 5'd0};

    // Table load while idle.
    add(0, 0, 0, 0, 1, 0, 7,    0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 18,   0, 0, 0);
    add(0, 0, 0, 0, 1, 3, 40,   0, 0, 0);
    add(0, 0, 0, 0, 1, 4, 1022, 0, 0, 0);
    add(0, 0, 0, 0, 1, 5, 11,   0, 0, 0);
    // Program 1: start, ignored start in RUN, jump, dual redirect, stall with jump, end.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    seq(0, 2);
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 3);
    seq(4, 5);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 5);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 40);
    add(0, 0, 1, 1, 0, 0, 0, 0, 0, 40);
    seq(7, 10);
    for (int k = 0; k < 3; k++) add(0, 1, 1, 0, 0, 0, 0, 1, 0, 10);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 10);
    seq(11, 12);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 12);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 12);
    // Program 2: restart from DONE, taken branch into the top of memory, wrap, end.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 12);
    seq(0, 7);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 7);
    seq(1022, 1023);
    seq(0, 12);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 12);
    // Program 3: redirect uses old table entry despite same-cycle write, then reset at pc 20.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 12);
    seq(0, 1);
    add(0, 0, 1, 0, 1, 1, 30, 0, 0, 1);
    seq(18, 20);
    reset_at = vq.size();
    // After reset: idle, then a jump through the cleared table lands on pc 0.
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    seq(0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    seq(0, 2);

    bus.start = 0; bus.stall = 0; bus.jump_en = 0; bus.branch_taken = 0;
    bus.tbl_we = 0; bus.tbl_idx = '0; bus.tbl_data = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst valid", 32'(bus.instr_valid), 0);
    check("rst done", 32'(bus.done), 0);
    check("rst pc", 32'(bus.pc), 0);
    check("rst imem_en", 32'(bus.imem_en), 0);
    check("rst imem_addr", 32'(bus.imem_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < vq.size(); n++) begin
      if (n == reset_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst valid", 32'(bus.instr_valid), 0);
        check("async rst pc", 32'(bus.pc), 0);
        check("async rst done", 32'(bus.done), 0);
        check("async rst imem_en", 32'(bus.imem_en), 0);
        check("async rst imem_addr", 32'(bus.imem_addr), 0);
        repeat (2) @(posedge clk);
        #1;
        check("held rst valid", 32'(bus.instr_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      apply(n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
